// File: rtl/vc_scrub_regfile_nrmw.sv
// Multi-port register file with zero-latency reads, optional write-to-read bypass
// and a one-entry-per-cycle scrub engine that wipes the file on a domain switch.

module vc_scrub_regfile_nrmw_chk #(
    parameter int p_num_entries     = 8,
    parameter int p_num_write_ports = 2,
    parameter int c_addr_nbits      = 3
)(
    input  logic                                      clk,
    input  logic                                      reset,
    input  logic [p_num_write_ports-1:0]              write_en,
    input  logic [p_num_write_ports*c_addr_nbits-1:0] write_addr,
    input  logic                                      sd
);

    // Flag X enables/labels and writes aimed past the last entry while out of reset.
    always @(posedge clk) begin
        if (reset) begin
            assert (!$isunknown(write_en));
            assert (!$isunknown(sd));
            for (int j = 0; j < p_num_write_ports; j++) begin
                if (write_en[j]) begin
                    assert (int'(write_addr[j*c_addr_nbits +: c_addr_nbits]) < p_num_entries);
                end
            end
        end
    end

endmodule

module vc_scrub_regfile_nrmw #(
    parameter int                      p_data_nbits      = 32,
    parameter int                      p_num_entries     = 8,
    parameter int                      p_num_read_ports  = 2,
    parameter int                      p_num_write_ports = 2,
    parameter logic [p_data_nbits-1:0] p_reset_value     = {p_data_nbits{1'b0}},
    parameter bit                      p_bypass          = 1'b1,
    localparam int                     c_addr_nbits      = $clog2(p_num_entries)
)(
    input  logic                                      clk,
    input  logic                                      reset,
    input  logic [p_num_read_ports*c_addr_nbits-1:0]  read_addr,
    output logic [p_num_read_ports*p_data_nbits-1:0]  read_data,
    input  logic [p_num_write_ports-1:0]              write_en,
    input  logic [p_num_write_ports*c_addr_nbits-1:0] write_addr,
    input  logic [p_num_write_ports*p_data_nbits-1:0] write_data,
    input  logic                                      scrub_req,
    output logic                                      scrub_busy,
    output logic                                      scrub_done,
    input  logic                                      sd
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SCRUB = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    localparam logic [c_addr_nbits-1:0] c_last = c_addr_nbits'(p_num_entries - 1);
    localparam logic [c_addr_nbits-1:0] c_zero = {c_addr_nbits{1'b0}};
    localparam logic [c_addr_nbits-1:0] c_one  = {{(c_addr_nbits-1){1'b0}}, 1'b1};

    state_e                    state_q, state_d;
    logic [c_addr_nbits-1:0]   cnt_q, cnt_d;
    logic [p_data_nbits-1:0]   mem_q [p_num_entries];
    logic [p_data_nbits-1:0]   mem_d [p_num_entries];
    logic [p_data_nbits-1:0]   rd_word_s [p_num_read_ports];
    logic [c_addr_nbits-1:0]   rd_addr_s [p_num_read_ports];

    // Scrub sequencer: IDLE -> SCRUB (one entry per cycle) -> DONE for one cycle.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (scrub_req) begin
                    state_d = ST_SCRUB;
                    cnt_d   = c_zero;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SCRUB: begin
                if (cnt_q == c_last) begin
                    state_d = ST_DONE;
                    cnt_d   = c_zero;
                end else begin
                    cnt_d   = cnt_q + c_one;
                end
            end
            ST_DONE: begin
                if (scrub_req) begin
                    state_d = ST_SCRUB;
                end else begin
                    state_d = ST_IDLE;
                end
                cnt_d = c_zero;
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = c_zero;
            end
        endcase
    end

    // Entry next-state: scrub clears one entry, otherwise writes apply in port order
    // so the highest-indexed port wins; address compares drop out-of-range writes.
    always_comb begin
        mem_d = mem_q;
        case (state_q)
            ST_SCRUB: begin
                for (int e = 0; e < p_num_entries; e++) begin
                    mem_d[e] = (cnt_q == c_addr_nbits'(e)) ? p_reset_value : mem_q[e];
                end
            end
            default: begin
                for (int e = 0; e < p_num_entries; e++) begin
                    for (int j = 0; j < p_num_write_ports; j++) begin
                        mem_d[e] = (write_en[j] &&
                                    (write_addr[j*c_addr_nbits +: c_addr_nbits] == c_addr_nbits'(e)))
                                   ? write_data[j*p_data_nbits +: p_data_nbits] : mem_d[e];
                    end
                end
            end
        endcase
    end

    // Combinational read with optional same-cycle forwarding; a scrubbing file reads as reset.
    always_comb begin
        read_data = {(p_num_read_ports*p_data_nbits){1'b0}};
        for (int k = 0; k < p_num_read_ports; k++) begin
            rd_addr_s[k] = read_addr[k*c_addr_nbits +: c_addr_nbits];
            rd_word_s[k] = {p_data_nbits{1'b0}};
            for (int e = 0; e < p_num_entries; e++) begin
                rd_word_s[k] = (rd_addr_s[k] == c_addr_nbits'(e)) ? mem_q[e] : rd_word_s[k];
            end
            for (int j = 0; j < p_num_write_ports; j++) begin
                rd_word_s[k] = (p_bypass && write_en[j] &&
                                (int'(rd_addr_s[k]) < p_num_entries) &&
                                (write_addr[j*c_addr_nbits +: c_addr_nbits] == rd_addr_s[k]))
                               ? write_data[j*p_data_nbits +: p_data_nbits] : rd_word_s[k];
            end
            read_data[k*p_data_nbits +: p_data_nbits] =
                (state_q == ST_SCRUB) ? p_reset_value : rd_word_s[k];
        end
    end

    // State, counter and storage registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= c_zero;
            for (int e = 0; e < p_num_entries; e++) begin
                mem_q[e] <= p_reset_value;
            end
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mem_q   <= mem_d;
        end
    end

    assign scrub_busy = (state_q == ST_SCRUB);
    assign scrub_done = (state_q == ST_DONE);

    vc_scrub_regfile_nrmw_chk #(
        .p_num_entries     (p_num_entries),
        .p_num_write_ports (p_num_write_ports),
        .c_addr_nbits      (c_addr_nbits)
    ) u_chk (
        .clk        (clk),
        .reset      (reset),
        .write_en   (write_en),
        .write_addr (write_addr),
        .sd         (sd)
    );

endmodule

// File: doc/vc_scrub_regfile_nrmw.md
Name: vc_scrub_regfile_nrmw

Overview:
- Parametrised multi-read / multi-write register file.
- Per-entry synchronous reset, optional write-to-read bypass, and a sequential scrub engine that clears every entry to the reset value, one entry per cycle.
- Used as the processor GPR/state file: on a security-domain switch the pipeline requests a scrub so stale contents never become visible to the next domain.

Parameters:
p_data_nbits, 32, width of one entry
p_num_entries, 8, number of entries (>=2)
p_num_read_ports, 2, number of combinational read ports (>=1)
p_num_write_ports, 2, number of write ports (>=1)
p_reset_value, 0, value loaded by reset and by scrub
p_bypass, 1, 1 = same-cycle write data forwarded to matching reads; 0 = reads see stored value only
c_addr_nbits, $clog2(p_num_entries), local, not set externally

Ports:
clk  in  1  clock, label {L}
reset  in  1  synchronous, active-low reset (0 = reset), label {L}
read_addr  in  p_num_read_ports*c_addr_nbits  packed read addresses, port k at bits [k*c_addr_nbits +: c_addr_nbits], {Domain sd}
read_data  out  p_num_read_ports*p_data_nbits  packed read data, same packing, {Domain sd}
write_en  in  p_num_write_ports  per-port write enable, {Domain sd}
write_addr  in  p_num_write_ports*c_addr_nbits  packed write addresses, {Domain sd}
write_data  in  p_num_write_ports*p_data_nbits  packed write data, {Domain sd}
scrub_req  in  1  single-cycle scrub request, {Domain sd}
scrub_busy  out  1  high while scrub in progress, {Domain sd}
scrub_done  out  1  one-cycle pulse on scrub completion, {Domain sd}
sd  in  1  security domain label, {L}

Behaviour:
- Reset: sampled at posedge clk when reset==0.
  - All entries <= p_reset_value; FSM <= IDLE; scrub counter <= 0.
  - Registered outputs scrub_busy=0 and scrub_done=0.
  - Writes and scrub_req in the same cycle are ignored.
  - Reset mid-scrub aborts the scrub; no scrub_done pulse.
- Read: combinational, zero latency.
  - read_data[k] = entry[read_addr[k]].
  - Address >= p_num_entries returns 0.
- Bypass (p_bypass=1, FSM==IDLE or DONE): if any write port j has write_en[j]=1 and write_addr[j]==read_addr[k], read_data[k] = write_data[j] of the highest such j.
- Write:
  - Entry updated at posedge when write_en[j]=1 and FSM is IDLE or DONE.
  - Multiple ports to the same address: highest port index wins.
  - Out-of-range address: write dropped and the simulation assertion fires.
  - write_en must not be X outside reset (assertion).
- FSM states IDLE, SCRUB, DONE:
  - IDLE: scrub_req=1 at posedge -> SCRUB, counter <= 0. Writes in that same cycle still commit.
  - SCRUB: each posedge, entry[counter] <= p_reset_value and counter++. At counter==p_num_entries-1 -> DONE.
  - DONE: lasts 1 cycle. scrub_req=1 -> SCRUB (counter <= 0); else -> IDLE.
- Outputs: scrub_busy = (FSM==SCRUB); scrub_done = (FSM==DONE). Both derive from state flops only.
- In SCRUB:
  - All write_en are ignored (writes dropped, no queueing).
  - scrub_req is ignored.
  - Every read port returns p_reset_value regardless of address; no bypass.
- Scrub latency: request accepted at edge t; entries cleared at edges t+1..t+p_num_entries; scrub_busy high for p_num_entries cycles; scrub_done high for the cycle after the last clear.
- Counter wraps only via state exit. Counter width is c_addr_nbits; there is no overflow case.

Test Plan:
1. Reset low 1 cycle, then read all 8 addresses on both ports -> every read_data = 0; scrub_busy=0, scrub_done=0.
2. Write 0xDEADBEEF to addr 3 via port 0, read addr 3 same cycle with p_bypass=1 -> read_data=0xDEADBEEF same cycle, and still 0xDEADBEEF next cycle with write_en=0.
3. Ports 0 and 1 both write addr 5 (0x11111111 / 0x22222222) -> next cycle entry 5 = 0x22222222; bypass read same cycle also 0x22222222.
4. Fill entries 0..7 with 0xA0+i, pulse scrub_req -> scrub_busy high exactly 8 cycles; reads during busy = 0; write 0x55 to addr 2 during busy is dropped; scrub_done high 1 cycle; afterwards all entries read 0.
5. Assert reset low at the 4th scrub cycle -> next cycle FSM IDLE, scrub_busy=0, no scrub_done pulse, all entries 0.
6. scrub_req held high through DONE -> a second scrub starts immediately: scrub_busy goes 8 high, 1 low (done), then 8 high again.
